f2h_wr_scheduler: RTL and testbench

F2H_WR_SCHEDULER -- requirements
Module: f2h_wr_scheduler

---
 rtl/f2h_wr_scheduler_pkg.sv | 30 +++
 rtl/f2h_wr_scheduler_sync_fifo.sv | 71 +++++++
 rtl/f2h_wr_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_f2h_wr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f2h_wr_scheduler_pkg.sv
// Shared definitions for the FIFO-to-host AXI3 write scheduler:
// FSM state encoding, fixed AXI attribute constants and a small min helper.
package f2h_wr_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } state_e;

   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
   localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [3:0] AXI_AWCACHE     = 4'b0011;
   localparam logic [4:0] AXI_AWUSER      = 5'b00000;
   localparam logic [3:0] AXI_WSTRB_ALL   = 4'hF;

   // Unsigned minimum used when sizing a burst against several limits.
   function automatic logic [16:0] umin17(input logic [16:0] a, input logic [16:0] b);
      if (a < b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/f2h_wr_scheduler_sync_fifo.sv
// Synchronous word FIFO with occupancy count; head word is shown on dout.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign push_ok_s = push && (count_q < DEPTH_C);
   assign pop_ok_s  = pop && (count_q != {CW{1'b0}});
   assign dout      = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Pointer and occupancy update; push and pop together leave count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers, cleared on reset so the FIFO reads empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/f2h_wr_scheduler.sv
// Drains a word FIFO into a host ring buffer as AXI3 INCR write bursts,
// one burst in flight, never crossing a 64-byte line or the ring end.
module f2h_wr_scheduler
   import f2h_wr_scheduler_pkg::*;
#(
   parameter int         BURST_LEN  = 16,
   parameter int         FIFO_DEPTH = 32,
   parameter int         TIMEOUT    = 1024,
   parameter logic [7:0] AXI_ID     = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        cfg_enable,
   input  logic [31:0] cfg_base,
   input  logic [15:0] cfg_size_words,
   output logic [15:0] wr_ptr,
   output logic        err,
   output logic [7:0]  m_awid,
   output logic [31:0] m_awaddr,
   output logic [3:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic [1:0]  m_awlock,
   output logic [3:0]  m_awcache,
   output logic [2:0]  m_awprot,
   output logic [4:0]  m_awuser,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [7:0]  m_wid,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [7:0]  m_bid,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
   localparam logic [IW-1:0] TMO_C   = IW'(TIMEOUT);

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic          rst_n_s;
   state_e        state_q, state_d;
   logic [4:0]    n_q, n_d;
   logic [4:0]    beat_q, beat_d;
   logic [15:0]   off_q, off_d;
   logic [31:0]   awaddr_q, awaddr_d;
   logic          err_q, err_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [CW-1:0] fifo_count_s;
   logic          push_s, pop_s, start_s, bad_resp_s;
   logic [16:0]   lim_s, nxt_s;
   logic [15:0]   off_next_s;
   logic          unused_s;

   // Reset asserts asynchronously but is released only on a clock edge.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Two-stage reset release synchroniser.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end
   assign rst_n_s = rst_sync_q[1];

   assign s_ready = (fifo_count_s < DEPTH_C);
   assign push_s  = s_valid && s_ready;

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n_s),
      .push  (push_s),
      .din   (s_data),
      .pop   (pop_s),
      .dout  (m_wdata),
      .count (fifo_count_s)
   );

   // Burst sizing against FIFO level, burst cap, 64-byte line and ring end.
   always_comb begin
      lim_s = umin17(umin17(17'(fifo_count_s), 17'(BURST_LEN)),
                     umin17(17'd16 - {13'd0, off_q[3:0]},
                            {1'b0, cfg_size_words} - {1'b0, off_q}));
      nxt_s = {1'b0, off_q} + {12'd0, n_q};
      if (nxt_s >= {1'b0, cfg_size_words}) begin
         off_next_s = 16'd0;
      end else begin
         off_next_s = nxt_s[15:0];
      end
      start_s = (state_q == ST_IDLE) && cfg_enable &&
                ((fifo_count_s >= BL_C) ||
                 ((fifo_count_s != {CW{1'b0}}) && (idle_q == TMO_C)));
      bad_resp_s = (state_q == ST_B) && m_bvalid && (m_bresp != AXI_RESP_OKAY);
   end

   // Scheduler FSM: next state, burst bookkeeping and FIFO pop.
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      beat_d   = beat_q;
      off_d    = off_q;
      awaddr_d = awaddr_q;
      pop_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d  = ST_AW;
               n_d      = lim_s[4:0];
               beat_d   = 5'd0;
               awaddr_d = cfg_base + {14'd0, off_q, 2'b00};
            end else begin
               state_d = ST_IDLE;
            end
            if (!cfg_enable) begin
               off_d = 16'd0;
            end else begin
               off_d = off_q;
            end
         end
         ST_AW: begin
            if (m_awready) begin
               state_d = ST_W;
            end else begin
               state_d = ST_AW;
            end
         end
         ST_W: begin
            if (m_wready) begin
               pop_s = 1'b1;
               if (beat_q == (n_q - 5'd1)) begin
                  state_d = ST_B;
               end else begin
                  beat_d = beat_q + 5'd1;
               end
            end else begin
               state_d = ST_W;
            end
         end
         ST_B: begin
            if (m_bvalid) begin
               state_d = ST_IDLE;
               if (cfg_enable) begin
                  off_d = off_next_s;
               end else begin
                  off_d = 16'd0;
               end
            end else begin
               state_d = ST_B;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky error and the saturating idle counter that drives flushes.
   always_comb begin
      if (!cfg_enable) begin
         err_d = 1'b0;
      end else if (bad_resp_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
      if (push_s || start_s) begin
         idle_d = {IW{1'b0}};
      end else if ((state_q == ST_IDLE) && (fifo_count_s != {CW{1'b0}}) && (idle_q != TMO_C)) begin
         idle_d = idle_q + IW'(1);
      end else begin
         idle_d = idle_q;
      end
   end

   // State registers; reset abandons any burst in progress.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q  <= ST_IDLE;
         n_q      <= 5'd0;
         beat_q   <= 5'd0;
         off_q    <= 16'd0;
         awaddr_q <= 32'd0;
         err_q    <= 1'b0;
         idle_q   <= {IW{1'b0}};
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         beat_q   <= beat_d;
         off_q    <= off_d;
         awaddr_q <= awaddr_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
      end
   end

   // Only one burst is ever outstanding, so the committed pointer equals the issue offset.
   assign wr_ptr    = off_q;
   assign err       = err_q;
   assign m_awid    = AXI_ID;
   assign m_awaddr  = awaddr_q;
   assign m_awlen   = n_q[3:0] - 4'd1;
   assign m_awsize  = AXI_SIZE_4B;
   assign m_awburst = AXI_BURST_INCR;
   assign m_awlock  = AXI_LOCK_NORMAL;
   assign m_awcache = AXI_AWCACHE;
   assign m_awprot  = AXI_PROT_NONE;
   assign m_awuser  = AXI_AWUSER;
   assign m_awvalid = (state_q == ST_AW);
   assign m_wid     = AXI_ID;
   assign m_wstrb   = AXI_WSTRB_ALL;
   assign m_wvalid  = (state_q == ST_W);
   assign m_wlast   = (state_q == ST_W) && (beat_q == (n_q - 5'd1));
   assign m_bready  = (state_q == ST_B);
   assign unused_s  = ^{m_bid, lim_s[16:5], n_q[4]};

endmodule

// File: tb/tb_f2h_wr_scheduler.sv
// Scoreboard bench for f2h_wr_scheduler: directed pushes queue expected AW
// addresses/lengths and W data; a negedge monitor checks every handshake.
module tb_f2h_wr_scheduler;
   localparam int         BL   = 16;
   localparam int         FD   = 32;
   localparam int         TMO  = 32;
   localparam logic [7:0] ID   = 8'h5A;
   localparam logic [31:0] BASE = 32'h3000_0000;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
   } aw_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] s_data;
   logic        s_valid, s_ready, cfg_enable;
   logic [31:0] cfg_base;
   logic [15:0] cfg_size_words, wr_ptr;
   logic        err;
   logic [7:0]  m_awid, m_wid, m_bid;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_awlen, m_awcache, m_wstrb;
   logic [2:0]  m_awsize, m_awprot;
   logic [1:0]  m_awburst, m_awlock, m_bresp;
   logic [4:0]  m_awuser;
   logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

   aw_t         exp_aw[$];
   logic [31:0] exp_data[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   f2h_wr_scheduler #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .TIMEOUT(TMO), .AXI_ID(ID)) dut (
      .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .cfg_enable(cfg_enable), .cfg_base(cfg_base), .cfg_size_words(cfg_size_words),
      .wr_ptr(wr_ptr), .err(err),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      int g;
      g = 0;
      s_data  = d;
      s_valid = 1'b1;
      exp_data.push_back(d);
      @(negedge clk);
      while (!s_ready && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (!s_ready) chk("push_stall", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [31:0] seed);
      for (int i = 0; i < n; i++) push_word(seed + 32'(i));
   endtask

   task automatic exp_burst(input logic [31:0] a, input logic [3:0] l);
      aw_t e;
      e.addr = a;
      e.len  = l;
      exp_aw.push_back(e);
   endtask

   task automatic drained(input string nm);
      chk({nm, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
      chk({nm, "_w_left"}, 32'(exp_data.size()), 32'd0);
   endtask

   task automatic disable_pulse();
      cfg_enable = 1'b0;
      cyc(2);
      chk("disabled_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("disabled_err", 32'(err), 32'd0);
   endtask

   // B-channel responder: answers each bready with a one-cycle bvalid.
   initial begin
      m_bvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (m_bready && !m_bvalid) m_bvalid = 1'b1;
         else m_bvalid = 1'b0;
      end
   end

   // Monitor: compares every AW and W handshake against the scoreboard.
   initial begin
      aw_t e;
      logic [3:0] cur_len;
      int beat;
      logic aw_open;
      aw_open = 1'b0;
      beat    = 0;
      cur_len = 4'd0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            aw_open = 1'b0;
            beat    = 0;
         end else begin
            if (m_awvalid && m_awready) begin
               if (exp_aw.size() == 0) begin
                  chk("aw_unexpected", m_awaddr, 32'hFFFF_FFFF);
               end else begin
                  e = exp_aw.pop_front();
                  chk("awaddr", m_awaddr, e.addr);
                  chk("awlen", 32'(m_awlen), 32'(e.len));
                  chk("aw_const", {5'd0, m_awid, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awuser},
                      {5'd0, ID, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 5'b00000});
                  cur_len = e.len;
               end
               aw_open = 1'b1;
               beat    = 0;
            end
            if (m_wvalid && m_wready) begin
               chk("w_after_aw", 32'(aw_open), 32'd1);
               if (exp_data.size() == 0) chk("w_unexpected", m_wdata, 32'hDEAD_BEEF);
               else chk("wdata", m_wdata, exp_data.pop_front());
               chk("wlast", 32'(m_wlast), 32'(beat == int'(cur_len)));
               chk("w_side", {20'd0, m_wid, m_wstrb}, {20'd0, ID, 4'hF});
               if (m_wlast) aw_open = 1'b0;
               beat++;
            end
         end
      end
   end

   // Directed test sequence.
   initial begin
      reset_n = 1'b0;
      s_data = 32'd0; s_valid = 1'b0; cfg_enable = 1'b0;
      cfg_base = BASE; cfg_size_words = 16'd64;
      m_awready = 1'b1; m_wready = 1'b1; m_bid = ID; m_bresp = 2'b00;
      cyc(3);
      chk("rst_awvalid", 32'(m_awvalid), 32'd0);
      chk("rst_wvalid", 32'(m_wvalid), 32'd0);
      chk("rst_wlast", 32'(m_wlast), 32'd0);
      chk("rst_bready", 32'(m_bready), 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      reset_n = 1'b1;
      cyc(4);
      cfg_enable = 1'b1;

      // Full 16-word burst from the ring base.
      exp_burst(BASE, 4'd15);
      push_n(16, 32'h0000_1000);
      cyc(60);
      chk("full_burst_wr_ptr", 32'(wr_ptr), 32'd16);
      drained("full_burst");
      disable_pulse();
      cfg_enable = 1'b1;

      // Three words flushed by the idle timeout.
      exp_burst(BASE, 4'd2);
      push_n(3, 32'h0000_2000);
      cyc(TMO + 48);
      chk("timeout_wr_ptr", 32'(wr_ptr), 32'd3);
      drained("timeout");

      // Move to offset 13, then a burst split at the 64-byte line.
      exp_burst(BASE + 32'h0C, 4'd9);
      push_n(10, 32'h0000_3000);
      cyc(TMO + 48);
      chk("off13_wr_ptr", 32'(wr_ptr), 32'd13);
      exp_burst(BASE + 32'h34, 4'd2);
      exp_burst(BASE + 32'h40, 4'd4);
      push_n(8, 32'h0000_3100);
      cyc(2 * TMO + 70);
      chk("line_split_wr_ptr", 32'(wr_ptr), 32'd21);
      drained("line_split");

      // 32-word ring: third burst wraps back to the base.
      cfg_enable = 1'b0;
      cyc(2);
      cfg_size_words = 16'd32;
      cfg_enable = 1'b1;
      exp_burst(BASE, 4'd15);
      exp_burst(BASE + 32'h40, 4'd15);
      exp_burst(BASE, 4'd15);
      push_n(48, 32'h0000_4000);
      cyc(150);
      chk("wrap_wr_ptr", 32'(wr_ptr), 32'd16);
      drained("wrap");

      // SLVERR response sets the sticky error but still commits.
      cfg_enable = 1'b0;
      cyc(2);
      cfg_size_words = 16'd64;
      cfg_enable = 1'b1;
      m_bresp = 2'b10;
      exp_burst(BASE, 4'd15);
      push_n(16, 32'h0000_5000);
      cyc(60);
      chk("slverr_err", 32'(err), 32'd1);
      chk("slverr_wr_ptr", 32'(wr_ptr), 32'd16);
      m_bresp = 2'b00;
      cyc(5);
      chk("err_sticky", 32'(err), 32'd1);
      drained("slverr");
      disable_pulse();
      cfg_enable = 1'b1;

      // Back-pressure on AW: FIFO fills to capacity without losing words.
      m_awready = 1'b0;
      exp_burst(BASE, 4'd15);
      exp_burst(BASE + 32'h40, 4'd15);
      exp_burst(BASE + 32'h80, 4'd7);
      fork
         push_n(40, 32'h0000_6000);
         begin
            cyc(60);
            chk("full_s_ready", 32'(s_ready), 32'd0);
            m_awready = 1'b1;
         end
      join
      cyc(TMO + 100);
      chk("backpressure_wr_ptr", 32'(wr_ptr), 32'd40);
      drained("backpressure");

      // Reset in the middle of a W burst abandons it at once.
      exp_burst(BASE + 32'hA0, 4'd7);
      push_n(16, 32'h0000_7000);
      for (int i = 0; i < 50 && !m_wvalid; i++) cyc(1);
      chk("mid_w_started", 32'(m_wvalid), 32'd1);
      cyc(2);
      reset_n = 1'b0;
      #1;
      chk("midrst_wvalid", 32'(m_wvalid), 32'd0);
      chk("midrst_wlast", 32'(m_wlast), 32'd0);
      chk("midrst_awvalid", 32'(m_awvalid), 32'd0);
      chk("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("midrst_s_ready", 32'(s_ready), 32'd1);
      exp_aw.delete();
      exp_data.delete();
      cyc(3);
      reset_n = 1'b1;
      cyc(4);
      chk("post_rst_bready", 32'(m_bready), 32'd0);
      chk("post_rst_wr_ptr", 32'(wr_ptr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so a stuck handshake cannot hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
